prefetch_issue_scheduler: RTL and testbench



---
 rtl/prefetch_pkg.sv | 16 +
 rtl/lowest_free_tag_encoder.sv | 20 ++
 rtl/prefetch_issue_scheduler.sv | 113 +++++++++++
 tb/tb_prefetch_issue_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared constants and state type for the prefetch issue scheduler.
package prefetch_pkg;

  localparam int unsigned LINE            = 18;
  localparam int unsigned MAX_OUTSTANDING = 8;
  localparam int unsigned TAG_W           = $clog2(MAX_OUTSTANDING);
  localparam int unsigned AVAIL_W         = 9;
  localparam int unsigned FIFO_ELEMS      = 256;
  localparam int unsigned PUSH_W          = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/lowest_free_tag_encoder.sv
// Priority encoder returning the lowest set bit of a free-tag mask.
module lowest_free_tag_encoder #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     free_mask,
  output logic [IDX_W-1:0] idx,
  output logic             any_free
);

  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (free_mask[i]) idx = IDX_W'(i);
    end
    any_free = |free_mask;
  end

endmodule

// File: rtl/prefetch_issue_scheduler.sv
// Drains the prefetch FIFO into tagged memory requests, one per cycle,
// tracking exact FIFO occupancy and a pool of in-flight tags.
module prefetch_issue_scheduler
  import prefetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PUSH_W-1:0]  push_count,
  output logic               fifo_re,
  input  logic [LINE-1:0]    fifo_dat_r,
  input  logic               pause,
  input  logic               flush,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [LINE-1:0]    mem_req_addr,
  output logic [TAG_W-1:0]   mem_req_tag,
  input  logic               mem_resp_valid,
  input  logic [TAG_W-1:0]   mem_resp_tag,
  output logic [TAG_W:0]     outstanding,
  output logic               idle,
  output logic               err
);

  localparam int unsigned SUM_W = AVAIL_W + 2;
  localparam int unsigned CNT_W = TAG_W + 1;

  state_t                     state;
  logic [TAG_W-1:0]           tag_reg;
  logic [MAX_OUTSTANDING-1:0] free_mask;
  logic [AVAIL_W-1:0]         avail;

  logic [TAG_W-1:0]           alloc_tag;
  logic                       any_free;
  logic                       handshake;
  logic                       flush_drop;
  logic                       resp_hit;
  logic                       resp_err;
  logic [SUM_W-1:0]           avail_sum;
  logic [AVAIL_W-1:0]         avail_next;
  logic                       avail_bad;
  logic [MAX_OUTSTANDING-1:0] free_mask_next;
  logic [CNT_W-1:0]           alloc_count;

  lowest_free_tag_encoder #(
    .N     (MAX_OUTSTANDING),
    .IDX_W (TAG_W)
  ) u_tag_enc (
    .free_mask (free_mask),
    .idx       (alloc_tag),
    .any_free  (any_free)
  );

  // Fetch decision, occupancy update and free-pool bookkeeping.
  always_comb begin
    handshake  = (state == ISSUE) && mem_req_ready;
    flush_drop = (state == ISSUE) && flush && !mem_req_ready;
    fifo_re    = (avail != '0) && any_free && !pause && !flush &&
                 ((state == IDLE) || handshake);

    resp_hit = mem_resp_valid && !free_mask[mem_resp_tag];
    resp_err = mem_resp_valid &&  free_mask[mem_resp_tag];

    avail_sum = SUM_W'(avail) + SUM_W'(push_count) - SUM_W'(fifo_re);
    avail_bad = 1'b0;
    if (avail_sum[SUM_W-1]) begin
      avail_next = '0;
      avail_bad  = 1'b1;
    end else if (avail_sum > SUM_W'(FIFO_ELEMS)) begin
      avail_next = AVAIL_W'(FIFO_ELEMS);
      avail_bad  = 1'b1;
    end else begin
      avail_next = AVAIL_W'(avail_sum);
    end

    // Allocation reads the registered mask, so it never collides with a free.
    free_mask_next = free_mask;
    if (fifo_re)    free_mask_next[alloc_tag]    = 1'b0;
    if (resp_hit)   free_mask_next[mem_resp_tag] = 1'b1;
    if (flush_drop) free_mask_next[tag_reg]      = 1'b1;

    alloc_count = '0;
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      alloc_count = alloc_count + CNT_W'(!free_mask[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tag_reg   <= '0;
      free_mask <= '1;
      avail     <= '0;
      err       <= 1'b0;
    end else begin
      free_mask <= free_mask_next;
      avail     <= avail_next;
      if (resp_err || avail_bad) err <= 1'b1;
      if (fifo_re) begin
        state   <= ISSUE;
        tag_reg <= alloc_tag;
      end else if (handshake || flush_drop) begin
        state   <= IDLE;
      end
    end
  end

  assign mem_req_valid = (state == ISSUE);
  assign mem_req_addr  = fifo_dat_r;
  assign mem_req_tag   = tag_reg;
  assign outstanding   = alloc_count;
  assign idle          = (state == IDLE) && (avail == '0) && (alloc_count == '0);

endmodule

// File: tb/tb_prefetch_issue_scheduler.sv
// Self-checking bench: directed table, corner sequences and random traffic
// against a behavioural model of the scheduler and its FIFO.
module tb_prefetch_issue_scheduler;

  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  push_count;
  logic        fifo_re;
  logic [17:0] fifo_dat_r;
  logic        pause;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [17:0] mem_req_addr;
  logic [2:0]  mem_req_tag;
  logic        mem_resp_valid;
  logic [2:0]  mem_resp_tag;
  logic [3:0]  outstanding;
  logic        idle;
  logic        err;

  prefetch_issue_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .push_count     (push_count),
    .fifo_re        (fifo_re),
    .fifo_dat_r     (fifo_dat_r),
    .pause          (pause),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_tag    (mem_req_tag),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_tag   (mem_resp_tag),
    .outstanding    (outstanding),
    .idle           (idle),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_free [MAXO];
  int          m_avail;
  bit          m_staged;
  int          m_tag;
  logic [17:0] m_addr;
  bit          m_err;
  logic [17:0] m_q[$];
  logic [17:0] env_q[$];
  int          inflight_q[$];
  logic [17:0] next_val = 18'd100;

  // Samples taken at the falling edge of the last cycle
  logic        s_re, s_valid, s_idle, s_err;
  logic [2:0]  s_tag;
  logic [3:0]  s_out;
  logic [17:0] s_addr;

  typedef struct {
    logic [2:0] push;
    logic       rdy;
    logic       rv;
    logic [2:0] rt;
    logic       re;
    logic       vld;
    logic [2:0] tag;
    logic [3:0] out;
    logic       idl;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_out();
    int n = 0;
    foreach (m_free[i]) if (!m_free[i]) n++;
    return n;
  endfunction

  function automatic bit model_re();
    return !reset && m_avail > 0 && model_out() < MAXO && !pause && !flush &&
           (!m_staged || mem_req_ready);
  endfunction

  task automatic model_step(input bit re);
    bit resp_ok;
    int t;
    if (reset) begin
      foreach (m_free[i]) m_free[i] = 1'b1;
      m_avail = 0; m_staged = 0; m_tag = 0; m_err = 0;
      m_q.delete(); inflight_q.delete();
      return;
    end
    if (m_staged && mem_req_ready) inflight_q.push_back(m_tag);
    resp_ok = 0;
    if (mem_resp_valid) begin
      t = int'(mem_resp_tag);
      if (m_free[t]) m_err = 1; else resp_ok = 1;
      for (int i = 0; i < inflight_q.size(); i++)
        if (inflight_q[i] == t) begin inflight_q.delete(i); break; end
    end
    if (re) begin
      t = 0;
      while (!m_free[t]) t++;
      m_free[t] = 0; m_staged = 1; m_tag = t;
      if (m_q.size() > 0) m_addr = m_q.pop_front();
    end else if (m_staged && (mem_req_ready || flush)) begin
      if (!mem_req_ready) m_free[m_tag] = 1;
      m_staged = 0;
    end
    if (resp_ok) m_free[int'(mem_resp_tag)] = 1;
    m_avail = m_avail + int'(push_count) - int'(re);
    if (m_avail > 256) begin m_err = 1; m_avail = 256; end
    else if (m_avail < 0) begin m_err = 1; m_avail = 0; end
    for (int k = 0; k < int'(push_count); k++) begin
      m_q.push_back(next_val);
      env_q.push_back(next_val);
      next_val = next_val + 18'd1;
    end
  endtask

  // The bench plays the FIFO: data for a read appears the cycle after fifo_re.
  task automatic env_step(input logic act_re);
    if (reset) env_q.delete();
    else if (act_re === 1'b1 && env_q.size() > 0) fifo_dat_r = env_q.pop_front();
  endtask

  task automatic cycle();
    bit   exp_re;
    logic act_re;
    @(negedge clk);
    exp_re = model_re();
    s_re = fifo_re; s_valid = mem_req_valid; s_tag = mem_req_tag;
    s_out = outstanding; s_idle = idle; s_err = err; s_addr = mem_req_addr;
    if (!reset) begin
      chk("fifo_re", 32'(s_re), 32'(exp_re));
      chk("mem_req_valid", 32'(s_valid), 32'(m_staged));
      if (m_staged) chk("mem_req_addr", 32'(s_addr), 32'(m_addr));
      chk("mem_req_tag", 32'(s_tag), 32'(m_tag));
      chk("outstanding", 32'(s_out), 32'(model_out()));
      chk("idle", 32'(s_idle), 32'(!m_staged && m_avail == 0 && model_out() == 0));
      chk("err", 32'(s_err), 32'(m_err));
    end
    act_re = fifo_re;
    @(posedge clk);
    #1;
    env_step(act_re);
    model_step(exp_re);
  endtask

  task automatic set_in(input logic [2:0] p, input logic rdy, input logic pa, input logic fl);
    push_count = p; mem_req_ready = rdy; pause = pa; flush = fl;
    mem_resp_valid = 1'b0; mem_resp_tag = '0;
  endtask

  task automatic do_reset();
    set_in(3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] v0;
    int total_re;
    bit drained;

    vecs[0]  = '{3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1};
    vecs[1]  = '{3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    vecs[2]  = '{3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 4'd1, 1'b0};
    vecs[3]  = '{3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 4'd2, 1'b0};
    vecs[4]  = '{3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, 4'd3, 1'b0};
    vecs[5]  = '{3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 4'd4, 1'b0};
    vecs[6]  = '{3'd0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd3, 4'd4, 1'b0};
    vecs[7]  = '{3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 4'd3, 1'b0};
    vecs[8]  = '{3'd0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd3, 4'd2, 1'b0};
    vecs[9]  = '{3'd0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 3'd3, 4'd1, 1'b0};
    vecs[10] = '{3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 4'd0, 1'b1};

    fifo_dat_r = '0;
    do_reset();
    chk("reset_err", 32'(err), 32'd0);

    // Burst of four drained back-to-back, then out-of-order responses
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].push, vecs[i].rdy, 1'b0, 1'b0);
      mem_resp_valid = vecs[i].rv;
      mem_resp_tag   = vecs[i].rt;
      cycle();
      chk($sformatf("vec%0d_re", i),   32'(s_re),    32'(vecs[i].re));
      chk($sformatf("vec%0d_vld", i),  32'(s_valid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_tag", i),  32'(s_tag),   32'(vecs[i].tag));
      chk($sformatf("vec%0d_out", i),  32'(s_out),   32'(vecs[i].out));
      chk($sformatf("vec%0d_idle", i), 32'(s_idle),  32'(vecs[i].idl));
    end

    // Tag exhaustion and reuse of a freed tag
    do_reset();
    set_in(3'd4, 1'b1, 1'b0, 1'b0); cycle();
    set_in(3'd4, 1'b1, 1'b0, 1'b0); cycle();
    set_in(3'd2, 1'b1, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 11; i++) begin set_in(3'd0, 1'b1, 1'b0, 1'b0); cycle(); end
    chk("exhaust_out", 32'(s_out), 32'd8);
    chk("exhaust_re", 32'(s_re), 32'd0);
    set_in(3'd0, 1'b1, 1'b0, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_tag = 3'd5;
    cycle();
    chk("resp_cycle_re", 32'(s_re), 32'd0);
    set_in(3'd0, 1'b1, 1'b0, 1'b0); cycle();
    chk("reuse_re", 32'(s_re), 32'd1);
    cycle();
    chk("reuse_valid", 32'(s_valid), 32'd1);
    chk("reuse_tag", 32'(s_tag), 32'd5);

    // Backpressure holds the staged request
    do_reset();
    v0 = next_val;
    set_in(3'd2, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd0, 1'b0, 1'b0, 1'b0); cycle();
    chk("bp_first_re", 32'(s_re), 32'd1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("bp_valid", 32'(s_valid), 32'd1);
      chk("bp_addr", 32'(s_addr), 32'(v0));
      chk("bp_tag", 32'(s_tag), 32'd0);
      chk("bp_re", 32'(s_re), 32'd0);
    end
    set_in(3'd0, 1'b1, 1'b0, 1'b0); cycle();
    chk("bp_release_re", 32'(s_re), 32'd1);
    cycle();
    chk("bp_next_tag", 32'(s_tag), 32'd1);
    chk("bp_next_addr", 32'(s_addr), 32'(v0 + 18'd1));

    // Flush of a stalled request returns its tag, leaves occupancy alone
    do_reset();
    set_in(3'd2, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd0, 1'b0, 1'b0, 1'b0); cycle();
    cycle();
    chk("fl_staged_out", 32'(s_out), 32'd1);
    set_in(3'd0, 1'b0, 1'b1, 1'b1); cycle();
    chk("fl_cycle_re", 32'(s_re), 32'd0);
    set_in(3'd0, 1'b0, 1'b1, 1'b0); cycle();
    chk("fl_valid", 32'(s_valid), 32'd0);
    chk("fl_out", 32'(s_out), 32'd0);
    chk("fl_idle", 32'(s_idle), 32'd0);
    set_in(3'd0, 1'b0, 1'b0, 1'b0); cycle();
    chk("fl_refetch_re", 32'(s_re), 32'd1);
    cycle();
    chk("fl_refetch_tag", 32'(s_tag), 32'd0);

    // Response to a free tag is a sticky error
    do_reset();
    set_in(3'd0, 1'b1, 1'b0, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_tag = 3'd6;
    cycle();
    chk("bad_resp_err0", 32'(s_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      set_in(3'd0, 1'b1, 1'b0, 1'b0); cycle();
      chk("bad_resp_sticky", 32'(s_err), 32'd1);
    end
    do_reset();
    set_in(3'd0, 1'b1, 1'b0, 1'b0); cycle();
    chk("err_cleared", 32'(s_err), 32'd0);

    // Occupancy overflow saturates at 256
    do_reset();
    total_re = 0;
    for (int i = 0; i < 65; i++) begin
      set_in(3'd4, 1'b0, 1'b0, 1'b0); cycle();
      if (s_re === 1'b1) total_re++;
    end
    chk("ovf_err_before", 32'(s_err), 32'd0);
    drained = 0;
    for (int c = 0; c < 1000 && !drained; c++) begin
      set_in(3'd0, 1'b1, 1'b0, 1'b0);
      if (inflight_q.size() > 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_tag = 3'(inflight_q[$urandom_range(0, inflight_q.size() - 1)]);
      end
      cycle();
      if (c == 0) chk("ovf_err_after", 32'(s_err), 32'd1);
      if (s_re === 1'b1) total_re++;
      drained = (m_avail == 0 && !m_staged && inflight_q.size() == 0);
    end
    chk("ovf_drained", 32'(drained), 32'd1);
    chk("ovf_total_reads", 32'(total_re), 32'd257);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      set_in(3'd0, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
      end else begin
        if (m_avail < 200 && $urandom_range(0, 4) < 2) push_count = 3'($urandom_range(0, 4));
        mem_req_ready = ($urandom_range(0, 3) != 0);
        pause         = ($urandom_range(0, 9) == 0);
        flush         = ($urandom_range(0, 11) == 0);
        if (inflight_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_tag = 3'(inflight_q[$urandom_range(0, inflight_q.size() - 1)]);
        end
      end
      cycle();
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
